// File: rtl/manchester_tx_if.sv
// Word handshake between a producer and the Manchester line transmitter.
interface manchester_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/manchester_tx.sv
// Manchester line transmitter: '0' preamble then data MSB first, followed by an idle gap.
// A '1' is sent low-then-high, a '0' high-then-low, each half lasting CLK_DIV clocks.
module manchester_tx #(
  parameter int CLK_DIV       = 4,
  parameter int DATA_W        = 8,
  parameter int PREAMBLE_BITS = 4,
  parameter int GAP_BITS      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  manchester_tx_if.slave    tx,
  output logic              sig_out,
  output logic              tx_busy,
  output logic              tx_done
);
  localparam int BIT_MAX_A = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
  localparam int BIT_MAX   = (BIT_MAX_A > GAP_BITS) ? BIT_MAX_A : GAP_BITS;
  localparam int BW        = (BIT_MAX < 2) ? 1 : $clog2(BIT_MAX);
  localparam int HW        = $clog2(CLK_DIV);

  localparam logic [HW-1:0] HB_LAST   = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

  state_t            state, state_n;
  logic [HW-1:0]     hb_cnt, hb_cnt_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic              half, half_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              sig_n, done_n;
  logic              hb_last, bit_end;

  assign tx.tx_ready = (state == IDLE);
  assign tx_busy     = (state != IDLE);
  assign hb_last     = (hb_cnt == HB_LAST);
  assign bit_end     = hb_last && half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hb_cnt  <= '0;
      bit_cnt <= '0;
      half    <= 1'b0;
      sig_out <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      hb_cnt  <= hb_cnt_n;
      bit_cnt <= bit_cnt_n;
      half    <= half_n;
      sig_out <= sig_n;
      tx_done <= done_n;
    end
  end

  // The payload is data, not control, so it carries no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n   = state;
    hb_cnt_n  = hb_cnt;
    bit_cnt_n = bit_cnt;
    half_n    = half;
    shreg_n   = shreg;
    done_n    = 1'b0;
    sig_n     = 1'b0;

    if (state == IDLE) begin
      if (tx.tx_valid) begin
        state_n   = PREAMBLE;
        hb_cnt_n  = '0;
        bit_cnt_n = '0;
        half_n    = 1'b0;
        shreg_n   = tx.tx_data;
      end
    end else begin
      if (hb_last) begin
        hb_cnt_n = '0;
        half_n   = ~half;
      end else begin
        hb_cnt_n = hb_cnt + 1'b1;
      end

      if (bit_end) begin
        bit_cnt_n = bit_cnt + 1'b1;
        unique case (state)
          PREAMBLE: begin
            if (bit_cnt == PRE_LAST) begin
              state_n   = DATA;
              bit_cnt_n = '0;
            end
          end
          DATA: begin
            shreg_n = shreg << 1;
            if (bit_cnt == DATA_LAST) begin
              state_n   = (GAP_BITS > 0) ? GAP : IDLE;
              bit_cnt_n = '0;
              done_n    = 1'b1;
            end
          end
          GAP: begin
            if (bit_cnt == GAP_LAST) begin
              state_n   = IDLE;
              bit_cnt_n = '0;
            end
          end
          default: begin
            state_n   = IDLE;
            bit_cnt_n = '0;
          end
        endcase
      end
    end

    // Line level is derived from the position being entered so sig_out stays registered.
    case (state_n)
      PREAMBLE: sig_n = ~half_n;
      DATA:     sig_n = ~(shreg_n[DATA_W-1] ^ half_n);
      default:  sig_n = 1'b0;
    endcase
  end
endmodule
